// File: rtl/program_mem.sv
// Program memory with a byte-serial loader: words are assembled MSB-first from
// a valid/ready byte stream and written sequentially; fetches are served only while idle.
module program_mem #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] address,
  output logic [INST_W-1:0] instruction,
  output logic              inst_valid,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              loading,
  output logic              load_done
);

  localparam int NB    = INST_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic [INST_W-1:0]   word_q, word_d;
  logic [INST_W-1:0]   instr_q, instr_d;
  logic                ivld_q, ivld_d;
  logic                mem_we;
  logic [INST_W-1:0]   mem_q [DEPTH];

  // Requests longer than the memory are clamped so the pointer never wraps.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] n);
    if (n > (ADDR_W+1)'(DEPTH)) return (ADDR_W+1)'(DEPTH);
    return n;
  endfunction

  function automatic logic [INST_W-1:0] shift_in(input logic [INST_W-1:0] w,
                                                 input logic [7:0] b);
    return (w << 8) | INST_W'(b);
  endfunction

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    instr_d = instr_q;
    ivld_d  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // A fetch in the same cycle as load_start still sees pre-load contents.
        if (fetch_en) begin
          instr_d = mem_q[address];
          ivld_d  = 1'b1;
        end
        if (load_start) begin
          len_d   = clamp_len(load_len);
          ptr_d   = '0;
          bcnt_d  = '0;
          state_d = (clamp_len(load_len) == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (load_valid) begin
          word_d = shift_in(word_q, load_data);
          if (bcnt_q == BC_W'(NB - 1)) begin
            bcnt_d  = '0;
            state_d = WRITE;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
      WRITE: begin
        mem_we  = !rst;
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = (({1'b0, ptr_q} + (ADDR_W+1)'(1)) == len_q) ? DONE : RECV;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      instr_q <= '0;
      ivld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      instr_q <= instr_d;
      ivld_q  <= ivld_d;
    end
  end

  // Assembly register and memory array are data: never reset, so contents survive rst.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (mem_we) mem_q[ptr_q] <= word_q;
  end

  assign instruction = instr_q;
  assign inst_valid  = ivld_q;
  assign load_ready  = (state_q == RECV);
  assign loading     = (state_q != IDLE);
  assign load_done   = (state_q == DONE);

endmodule

// File: tb/tb_program_mem.sv
// Randomised bench for program_mem: a reference memory model predicts fetch results,
// which a monitor pops from a queue whenever inst_valid is seen.
module tb_program_mem;
  localparam int AW    = 4;
  localparam int IW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] address = '0;
  logic [IW-1:0] instruction;
  logic          inst_valid;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic [7:0]    load_data = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          loading;
  logic          load_done;

  program_mem #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .address(address),
    .instruction(instruction), .inst_valid(inst_valid),
    .load_start(load_start), .load_len(load_len), .load_data(load_data),
    .load_valid(load_valid), .load_ready(load_ready), .loading(loading),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  typedef struct {bit chk; logic [IW-1:0] d;} exp_t;
  exp_t          exp_q[$];
  logic [IW-1:0] ref_mem [DEPTH];
  bit            ref_known [DEPTH];
  logic [7:0]    byte_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  logic [IW-1:0] last_exp = '0;
  logic          rst_at_edge = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_at_edge <= rst;

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (load_done) done_cnt++;
      if (rst_at_edge) begin
        check("rst_instruction", 32'(instruction), 0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_load_ready", 32'(load_ready), 0);
        check("rst_loading", 32'(loading), 0);
        check("rst_load_done", 32'(load_done), 0);
        last_exp = '0;
      end else if (inst_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_valid: got inst_valid=1 required 0 (no fetch pending)");
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check("fetch_data", 32'(instruction), 32'(e.d));
          last_exp = e.chk ? e.d : instruction;
        end
      end else begin
        check("instruction_hold", 32'(instruction), 32'(last_exp));
      end
    end
  end

  // Called just after a falling edge; the fetch is only predicted when the model is idle.
  task automatic fetch_cycle(bit en, logic [AW-1:0] a);
    exp_t e;
    fetch_en = en;
    address  = a;
    if (en) begin
      e.chk = ref_known[a];
      e.d   = ref_mem[a];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_fetches(int n, bit seq);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      fetch_cycle(seq ? 1'b1 : ($urandom_range(0, 3) != 0),
                  seq ? AW'(k) : AW'($urandom_range(0, DEPTH - 1)));
    end
    @(negedge clk);
    fetch_en = 1'b0;
  endtask

  task automatic do_load(int len, bit gaps, int abort_after, bit extra_start, bit fetch_at_start);
    int         eff;
    int         nbytes;
    int         d0;
    int         i;
    int         cyc;
    int         k;
    bit         pend;
    bit         rdy;
    bit         v;
    logic [7:0] b[$];
    eff    = (len > DEPTH) ? DEPTH : len;
    nbytes = eff * 2;
    d0     = done_cnt;
    i      = 0;
    cyc    = 0;
    pend   = 0;
    b      = byte_q;
    byte_q.delete();
    while (b.size() < nbytes) b.push_back(8'($urandom));

    @(negedge clk);
    load_start = 1'b1;
    load_len   = (AW+1)'(len);
    if (fetch_at_start) fetch_cycle(1'b1, AW'($urandom_range(0, DEPTH - 1)));
    else fetch_en = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    if (eff == 0) check("len0_done_next_cycle", 32'(load_done), 1);
    else check("loading_high", 32'(loading), 1);

    while (i < nbytes && i < abort_after && cyc < 400) begin
      if (pend) begin
        check("ready_low_in_write", 32'(load_ready), 0);
        pend = 0;
      end
      rdy        = load_ready;
      v          = gaps ? (cyc % 2 == 0) : 1'b1;
      load_valid = v;
      load_data  = b[i];
      fetch_en   = 1'($urandom_range(0, 1));
      address    = AW'($urandom_range(0, DEPTH - 1));
      load_start = extra_start ? 1'($urandom_range(0, 1)) : 1'b0;
      load_len   = (AW+1)'($urandom_range(0, 31));
      if (rdy && v) begin
        i++;
        if (i % 2 == 0) pend = 1;
      end
      @(negedge clk);
      cyc++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    if (cyc >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: accepted %0d bytes, required %0d", i, nbytes);
    end
    if (pend) check("ready_low_in_write", 32'(load_ready), 0);

    if (abort_after < nbytes) begin
      rst      = 1'b1;
      fetch_en = 1'b0;
      for (int w = 0; w < i / 2; w++) begin
        ref_mem[w]   = {b[2*w], b[2*w+1]};
        ref_known[w] = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      fetch_cycle(1'b1, AW'(i / 2));
      @(negedge clk);
      fetch_en = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - d0), 0);
      check("abort_idle", 32'(loading), 0);
    end else begin
      k = 0;
      while (!load_done && k < 8) begin
        fetch_en = 1'($urandom_range(0, 1));
        address  = AW'($urandom_range(0, DEPTH - 1));
        @(negedge clk);
        k++;
      end
      fetch_en = 1'b0;
      check("done_seen", 32'(load_done), 1);
      check("ready_low_at_done", 32'(load_ready), 0);
      for (int w = 0; w < eff; w++) begin
        ref_mem[w]   = {b[2*w], b[2*w+1]};
        ref_known[w] = 1'b1;
      end
      @(negedge clk);
      check("done_one_cycle", 32'(load_done), 0);
      check("idle_after_done", 32'(loading), 0);
      check("done_count", 32'(done_cnt - d0), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    fetch_en = 1'b1;
    address  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fetch_cycle(1'b1, '0);
    @(negedge clk);
    fetch_en = 1'b0;

    byte_q = '{8'h1E, 8'h07, 8'h12, 8'h01, 8'hB4, 8'h01};
    do_load(3, 1'b0, 1000, 1'b0, 1'b0);
    do_fetches(3, 1'b1);

    do_load(20, 1'b0, 1000, 1'b0, 1'b1);
    do_fetches(16, 1'b1);

    do_load(2, 1'b1, 1000, 1'b0, 1'b0);
    do_fetches(4, 1'b1);

    do_load(0, 1'b0, 1000, 1'b0, 1'b1);
    do_fetches(16, 1'b1);

    do_load(2, 1'b0, 3, 1'b0, 1'b0);
    do_fetches(4, 1'b1);

    repeat (4) begin
      do_load($urandom_range(1, 17), 1'($urandom_range(0, 1)), 1000, 1'b1, 1'b1);
      do_fetches(12, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/program_mem.md
PROGRAM_MEM -- requirements
Module: program_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning word-address width; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter INST_W, default 16, meaning instruction width; a multiple of 8; NB = INST_W/8 bytes per word.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fetch_en  input  1  fetch request for the current cycle.
REQ-006 SHALL have port address  input  ADDR_W  fetch word address.
REQ-007 SHALL have port instruction  output  INST_W  registered fetched word.
REQ-008 SHALL have port inst_valid  output  1  instruction holds data fetched in the previous cycle.
REQ-009 SHALL have port load_start  input  1  begin a program load.
REQ-010 SHALL have port load_len  input  ADDR_W+1  number of words to load, sampled with load_start.
REQ-011 SHALL have port load_data  input  8  loader byte stream.
REQ-012 SHALL have port load_valid  input  1  load_data is valid.
REQ-013 SHALL have port load_ready  output  1  block accepts a byte this cycle.
REQ-014 SHALL have port loading  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port load_done  output  1  one-cycle pulse at load completion.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, WRITE, DONE.
REQ-017 In IDLE, load_start=1 SHALL latch len = min(load_len, 2**ADDR_W), clear word pointer and byte counter, and go to RECV; if len is 0 it SHALL go to DONE instead.
REQ-018 In RECV, load_ready SHALL be 1; a byte transfers only when load_valid and load_ready are both 1.
REQ-019 Bytes SHALL assemble MSB-first: the first byte of a word goes to bits [INST_W-1:INST_W-8].
REQ-020 On the NB-th accepted byte of a word, the state SHALL go to WRITE; load_ready SHALL be 0 outside RECV.
REQ-021 WRITE SHALL store the assembled word at the word pointer in one cycle and increment the pointer; it SHALL go to DONE when pointer+1 equals len, else back to RECV.
REQ-022 DONE SHALL assert load_done for exactly one cycle and then return to IDLE.
REQ-023 The pointer SHALL never wrap: len 2**ADDR_W writes addresses 0 through 2**ADDR_W-1 and then ends.
REQ-024 In IDLE with fetch_en=1, the next cycle SHALL have instruction = mem[address] and inst_valid=1; with fetch_en=0, inst_valid SHALL be 0 and instruction SHALL hold.
REQ-025 When not in IDLE, fetch_en SHALL be ignored, inst_valid SHALL be 0, and instruction SHALL hold.
REQ-026 If load_start and fetch_en are both 1 in IDLE, the fetch SHALL be served from the pre-load contents and the load SHALL begin.
REQ-027 load_start while loading SHALL be ignored.
REQ-028 Gaps in load_valid SHALL stall assembly with no byte loss or duplication.
REQ-029 Addresses that are not loaded SHALL keep their prior contents.

Reset
REQ-030 rst SHALL force state IDLE, instruction=0, inst_valid=0, load_ready=0, loading=0, load_done=0, and clear the pointer and byte counter.
REQ-031 Memory contents SHALL NOT be cleared by rst.
REQ-032 rst during a load SHALL abort it: words already written remain, any partial word is discarded, and load_done SHALL NOT pulse.

Verification (ADDR_W=4, INST_W=16)
REQ-033 Reset, then fetch_en=1, address=0 -> instruction=0 and inst_valid=0 during reset; after reset, inst_valid=1 one cycle after the fetch.
REQ-034 load_len=3 with bytes 1E,07,12,01,B4,01 -> mem[0..2]=1E07,1201,B401; load_done pulses once; fetching addresses 0..2 returns those words at 1-cycle latency.
REQ-035 load_len=2 with load_valid toggling every other cycle -> same words as an unstalled load; load_ready is 0 during each WRITE cycle.
REQ-036 load_len=20 -> clamps to 16 words; 32 bytes accepted; load_done pulses after mem[15] is written; pointer does not wrap.
REQ-037 load_len=0 -> load_done pulses the following cycle with no bytes accepted and memory unchanged.
REQ-038 rst after 3 bytes of a 2-word load -> mem[0] updated, mem[1] unchanged, no load_done, and fetch resumes the cycle after reset.
